fetch_pc_unit: RTL and testbench

//  Fetch stage directly upstream of the instruction memory (IM). Holds the PC,

---
 rtl/fetch_pc_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch stage in front of the instruction memory.
// Holds the PC, drives the IM word address, registers the returned word into
// an instruction register with a valid/ready handshake toward decode, applies
// branch / jump / jump-register redirects, and flags PCs that are misaligned
// or outside the IM window.
// Optional feature: define FETCH_PERF_EN to get saturating fetch/redirect
// counters; otherwise cnt_fetch and cnt_redir are tied to zero.
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned IM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    output logic [6:0]  im_addr,
    input  logic [31:0] im_data,
    input  logic        dec_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        redir_en,
    input  logic [1:0]  redir_type,
    input  logic [15:0] redir_imm16,
    input  logic [25:0] redir_idx26,
    input  logic [31:0] redir_reg,
    output logic        fetch_fault,
    output logic [31:0] pc,
    output logic [31:0] cnt_fetch,
    output logic [31:0] cnt_redir
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, FAULT} state_t;

    localparam logic [31:0] WINDOW_BYTES = 32'(IM_WORDS * 4);

    // A PC is illegal when misaligned or when its offset from PC_RESET falls
    // outside the IM window; the subtraction wraps so low PCs below PC_RESET
    // also land outside.
    function automatic logic pc_illegal(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - PC_RESET;
        return (addr[1:0] != 2'b00) || (offset >= WINDOW_BYTES);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] instr_pc_plus4;
    logic [31:0] redir_tgt;
    logic        redir_take;
    logic        load_en;

    assign pc_plus4       = pc_q + 32'd4;
    assign instr_pc_plus4 = instr_pc_q + 32'd4;
    assign redir_take     = redir_en && (redir_type != 2'b11) && (state_q != BOOT);

    // Redirect target for the instruction currently held in instr.
    always_comb begin
        redir_tgt = redir_reg;
        case (redir_type)
            2'b00:   redir_tgt = instr_pc_plus4 + {{14{redir_imm16[15]}}, redir_imm16, 2'b00};
            2'b01:   redir_tgt = {instr_pc_plus4[31:28], redir_idx26, 2'b00};
            default: redir_tgt = redir_reg;
        endcase
    end

    // Next-state logic: redirect beats load/stall; every new PC is fault-checked.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        load_en       = 1'b0;

        if (redir_take) begin
            pc_d          = redir_tgt;
            instr_valid_d = 1'b0;
            if (pc_illegal(redir_tgt)) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = RUN;
                fault_d = 1'b0;
            end
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (!instr_valid_q || dec_ready) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        load_en = 1'b1;
                    end
                end
                FAULT: begin
                    if (instr_valid_q && dec_ready) begin
                        instr_valid_d = 1'b0;
                    end
                end
                default: state_d = FAULT;
            endcase

            if (load_en) begin
                instr_d       = im_data;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = pc_plus4;
                if (pc_illegal(pc_plus4)) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    state_d = RUN;
                    fault_d = 1'b0;
                end
            end
        end
    end

    // State, PC and instruction register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= PC_RESET;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign im_addr     = pc_q[8:2];
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] cnt_fetch_q, cnt_fetch_d;
    logic [31:0] cnt_redir_q, cnt_redir_d;

    // Saturating event counters for loads and taken redirects.
    always_comb begin
        cnt_fetch_d = cnt_fetch_q;
        cnt_redir_d = cnt_redir_q;
        if (load_en && (cnt_fetch_q != 32'hFFFF_FFFF)) begin
            cnt_fetch_d = cnt_fetch_q + 32'd1;
        end
        if (redir_take && (cnt_redir_q != 32'hFFFF_FFFF)) begin
            cnt_redir_d = cnt_redir_q + 32'd1;
        end
    end

    // Counter registers cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_fetch_q <= 32'h0;
            cnt_redir_q <= 32'h0;
        end else begin
            cnt_fetch_q <= cnt_fetch_d;
            cnt_redir_q <= cnt_redir_d;
        end
    end

    assign cnt_fetch = cnt_fetch_q;
    assign cnt_redir = cnt_redir_q;
`else
    assign cnt_fetch = 32'h0;
    assign cnt_redir = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: scoreboard of expected (pc, word) pairs,
// pushed when stimulus is driven and popped whenever decode consumes a word.
module tb_fetch_pc_unit;

   logic        clock;
   logic        reset;
   logic [6:0]  imAddr;
   logic [31:0] imData;
   logic        decReady;
   logic [31:0] instr;
   logic [31:0] instrPc;
   logic        instrValid;
   logic        redirEn;
   logic [1:0]  redirType;
   logic [15:0] redirImm16;
   logic [25:0] redirIdx26;
   logic [31:0] redirReg;
   logic        fetchFault;
   logic [31:0] pc;
   logic [31:0] cntFetch;
   logic [31:0] cntRedir;

   logic [31:0] mem [128];
   logic [31:0] sbQ [$];
   int          checkCount = 0;
   int          errorCount = 0;
   int          expFetch = 0;
   int          expRedir = 0;

   fetch_pc_unit dut (
      .clk         (clock),
      .rst         (reset),
      .im_addr     (imAddr),
      .im_data     (imData),
      .dec_ready   (decReady),
      .instr       (instr),
      .instr_pc    (instrPc),
      .instr_valid (instrValid),
      .redir_en    (redirEn),
      .redir_type  (redirType),
      .redir_imm16 (redirImm16),
      .redir_idx26 (redirIdx26),
      .redir_reg   (redirReg),
      .fetch_fault (fetchFault),
      .pc          (pc),
      .cnt_fetch   (cntFetch),
      .cnt_redir   (cntRedir)
   );

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Combinational instruction memory model
   assign imData = mem[imAddr];

   // Compare one observed value against its expectation and count it
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Queue expected words for a run of sequential PCs
   task automatic pushSeq(input logic [31:0] startPc, input int count);
      for (int i = 0; i < count; i++) begin
         sbQ.push_back(startPc + 32'(4 * i));
      end
   endtask

   // Drive a one-cycle redirect, queue the words expected after it
   task automatic applyStimulus(input logic [1:0] rType, input logic [15:0] imm,
                                input logic [25:0] idx, input logic [31:0] regVal,
                                input logic [31:0] pushStart, input int pushCount);
      redirEn    = 1'b1;
      redirType  = rType;
      redirImm16 = imm;
      redirIdx26 = idx;
      redirReg   = regVal;
      if (rType != 2'b11) expRedir++;
      pushSeq(pushStart, pushCount);
      tick();
      redirEn = 1'b0;
   endtask

   // Wait (bounded) until the given PC is presented as a valid instruction
   task automatic waitInstrPc(input logic [31:0] target);
      int n;
      n = 0;
      while (!(instrValid && instrPc == target) && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) checkOutput("waitInstrPc", instrPc, target);
   endtask

   // Scoreboard consumer: a word leaves instr when decode takes it or redirects on it
   always @(negedge clock) begin
      logic [31:0] expPc;
      if (!reset && instrValid && (decReady || (redirEn && redirType != 2'b11))) begin
         if (sbQ.size() == 0) begin
            checkOutput("sbUnexpected", instrPc, 32'hFFFF_FFFF);
         end else begin
            expPc = sbQ.pop_front();
            expFetch++;
            checkOutput("sbInstrPc", instrPc, expPc);
            checkOutput("sbInstr", instr, mem[expPc[8:2]]);
         end
      end
   end

   // Main stimulus sequence
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem[0] = 32'h2002_0005;
      reset      = 1'b1;
      decReady   = 1'b1;
      redirEn    = 1'b0;
      redirType  = 2'b00;
      redirImm16 = 16'h0;
      redirIdx26 = 26'h0;
      redirReg   = 32'h0;

      tick();
      checkOutput("rstPc", pc, 32'h0);
      checkOutput("rstValid", {31'b0, instrValid}, 32'h0);
      checkOutput("rstInstr", instr, 32'h0);
      checkOutput("rstFault", {31'b0, fetchFault}, 32'h0);
      checkOutput("rstCntFetch", cntFetch, 32'h0);
      pushSeq(32'h0, 5);
      reset = 1'b0;

      tick();
      checkOutput("bootValid", {31'b0, instrValid}, 32'h0);
      checkOutput("bootPc", pc, 32'h0);
      tick();
      checkOutput("firstInstr", instr, 32'h2002_0005);
      checkOutput("firstInstrPc", instrPc, 32'h0);
      checkOutput("firstPc", pc, 32'h4);

      tick();
      decReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("holdPc", pc, 32'h8);
         checkOutput("holdInstrPc", instrPc, 32'h4);
         checkOutput("holdInstr", instr, mem[1]);
      end
      decReady = 1'b1;

      waitInstrPc(32'h10);
      applyStimulus(2'b00, 16'h0017, 26'h0, 32'h0, 32'h70, 3);
      checkOutput("brPc", pc, 32'h70);
      checkOutput("brValid", {31'b0, instrValid}, 32'h0);

      waitInstrPc(32'h78);
      applyStimulus(2'b01, 16'h0, 26'h20, 32'h0, 32'h80, 2);
      checkOutput("jPc", pc, 32'h80);

      waitInstrPc(32'h84);
      applyStimulus(2'b10, 16'h0, 26'h0, 32'h14, 32'h14, 2);
      checkOutput("jrPc", pc, 32'h14);

      waitInstrPc(32'h14);
      applyStimulus(2'b11, 16'h0, 26'h0, 32'h1F4, 32'h0, 0);
      checkOutput("rsvdPc", pc, 32'h1C);
      checkOutput("rsvdInstrPc", instrPc, 32'h18);

      applyStimulus(2'b10, 16'h0, 26'h0, 32'h1F4, 32'h1F4, 3);
      waitInstrPc(32'h1FC);
      decReady = 1'b0;
      checkOutput("edgeFault", {31'b0, fetchFault}, 32'h1);
      checkOutput("edgePc", pc, 32'h200);
      checkOutput("edgeImAddr", {25'b0, imAddr}, 32'h0);
      tick();
      tick();
      checkOutput("faultHoldValid", {31'b0, instrValid}, 32'h1);
      checkOutput("faultHoldPc", instrPc, 32'h1FC);
      decReady = 1'b1;
      tick();
      checkOutput("faultDropValid", {31'b0, instrValid}, 32'h0);
      tick();
      checkOutput("faultNoLoad", {31'b0, instrValid}, 32'h0);
      checkOutput("faultStill", {31'b0, fetchFault}, 32'h1);

      applyStimulus(2'b10, 16'h0, 26'h0, 32'h4, 32'h4, 2);
      checkOutput("recoverFault", {31'b0, fetchFault}, 32'h0);
      checkOutput("recoverPc", pc, 32'h4);

      waitInstrPc(32'h8);
      decReady = 1'b0;
      applyStimulus(2'b00, 16'hFFFE, 26'h0, 32'h0, 32'h4, 1);
      checkOutput("stallRedirPc", pc, 32'h4);
      checkOutput("stallRedirValid", {31'b0, instrValid}, 32'h0);
      decReady = 1'b1;

      waitInstrPc(32'h4);
      applyStimulus(2'b10, 16'h0, 26'h0, 32'h6, 32'h0, 0);
      checkOutput("misalignFault", {31'b0, fetchFault}, 32'h1);
      checkOutput("misalignPc", pc, 32'h6);
      tick();
      checkOutput("misalignValid", {31'b0, instrValid}, 32'h0);
      checkOutput("misalignImAddr", {25'b0, imAddr}, 32'h1);

      checkOutput("sbDrain", 32'(sbQ.size()), 32'h0);
`ifdef FETCH_PERF_EN
      checkOutput("cntFetch", cntFetch, 32'(expFetch));
      checkOutput("cntRedir", cntRedir, 32'(expRedir));
`else
      checkOutput("cntFetchOff", cntFetch, 32'h0);
      checkOutput("cntRedirOff", cntRedir, 32'h0);
`endif

      #3 reset = 1'b1;
      #1;
      checkOutput("asyncRstPc", pc, 32'h0);
      checkOutput("asyncRstFault", {31'b0, fetchFault}, 32'h0);
      checkOutput("asyncRstValid", {31'b0, instrValid}, 32'h0);
      checkOutput("asyncRstCnt", cntRedir, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
